// File: rtl/elm_neuron_mac.sv
// elm_neuron_mac
//   Hidden-layer neuron datapath. Takes one signed input sample per accepted
//   beat, reads the matching weight from an external memory with a one-cycle
//   registered read, multiply-accumulates the full-precision products, and
//   after numWeight beats emits one saturated pre-activation
//   sat((acc >>> fracBits) + bias) as a single-cycle out_valid pulse.
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     in_valid/ready  input sample handshake, in_data signed sample
//     bias            signed bias, held static for the whole frame
//     weight_ren      weight read enable (= accepted beat)
//     weight_raddr    weight read address, addressWidth+1 bits
//     weight_rdata    weight data, valid the cycle after weight_ren
//     out_valid       one-cycle pulse qualifying out_data
//     out_data        saturated neuron pre-activation
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting beats; last beat of the frame moves to DRAIN
// DRAIN | no accept; final product lands in the accumulator
// OUT   | no accept; register saturated result, clear accumulator
module elm_neuron_mac #(
   parameter int dataWidth    = 16,
   parameter int fracBits     = 8,
   parameter int addressWidth = 10,
   parameter int numWeight    = 784,
   parameter int accWidth     = 2*dataWidth+10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [dataWidth-1:0]      in_data,
   output logic                      in_ready,
   input  logic [dataWidth-1:0]      bias,
   output logic                      weight_ren,
   output logic [addressWidth:0]     weight_raddr,
   input  logic [dataWidth-1:0]      weight_rdata,
   output logic                      out_valid,
   output logic [dataWidth-1:0]      out_data
);

   localparam int ADDR_W = addressWidth + 1;
   localparam int PROD_W = 2 * dataWidth;
   localparam int SUM_W  = accWidth + 1;

   localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(numWeight - 1);
   localparam logic signed [SUM_W-1:0] SAT_MAX   = SUM_W'((2**(dataWidth-1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN   = SUM_W'(-(2**(dataWidth-1)));

   typedef enum logic [1:0] {
      ST_ACC   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_OUT   = 2'd2
   } state_t;

   state_t                       state_q, state_d;
   logic [ADDR_W-1:0]            addr_q, addr_d;
   logic signed [dataWidth-1:0]  x_q, x_d;
   logic                         v_q, v_d;
   logic signed [accWidth-1:0]   acc_q, acc_d;
   logic                         out_valid_q, out_valid_d;
   logic [dataWidth-1:0]         out_data_q, out_data_d;

   logic                         accept;
   logic signed [PROD_W-1:0]     prod;
   logic signed [accWidth-1:0]   acc_shr;
   logic signed [SUM_W-1:0]      sum;

   assign in_ready     = (state_q == ST_ACC);
   assign accept       = in_valid && in_ready;
   assign weight_ren   = accept;
   assign weight_raddr = addr_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;

   // Full-width signed product of the registered sample and the weight the
   // memory returns one cycle after the read.
   assign prod    = x_q * $signed(weight_rdata);
   assign acc_shr = acc_q >>> fracBits;
   assign sum     = $signed({acc_shr[accWidth-1], acc_shr})
                  + $signed({{(SUM_W-dataWidth){bias[dataWidth-1]}}, bias});

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      x_d         = x_q;
      v_d         = 1'b0;
      acc_d       = acc_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;

      if (accept) begin
         x_d = $signed(in_data);
         v_d = 1'b1;
      end

      if (v_q)
         acc_d = acc_q + {{(accWidth-PROD_W){prod[PROD_W-1]}}, prod};

      unique case (state_q)
         ST_ACC: begin
            if (accept) begin
               // Wrap only at frame end; the address is never allowed to roll
               // over on its own.
               if (addr_q == LAST_ADDR) begin
                  addr_d  = '0;
                  state_d = ST_DRAIN;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (sum > SAT_MAX)
               out_data_d = SAT_MAX[dataWidth-1:0];
            else if (sum < SAT_MIN)
               out_data_d = SAT_MIN[dataWidth-1:0];
            else
               out_data_d = sum[dataWidth-1:0];
            out_valid_d = 1'b1;
            acc_d       = '0;
            state_d     = ST_ACC;
         end
         default: begin
            state_d = ST_ACC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACC;
         addr_q      <= '0;
         x_q         <= '0;
         v_q         <= 1'b0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         x_q         <= x_d;
         v_q         <= v_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule
